gpio_axis_reader: RTL and testbench
===================================

// Module: gpio_axis_reader
// PURPOSE
//  GPIO-to-AXIS read bridge: drains one num_bits-wide AXI-stream word (e.g. result FIFO)
//  into a 16-bit shadow register and exposes it to software one byte per GPIO read strobe.
//  High byte is presented first, low byte second. Counterpart of the two-write GPIO
//  loader on the same gpio_in bus; bus field positions come from ising_config.
// PARAMETERS
//  rd_addr   2  GPIO address whose strobe acknowledges the currently presented byte
//  clr_addr  3  GPIO address whose strobe clears the underflow flag and the word counter
// PORTS
//  clk       in   1         system clock
//  rst       in   1         asynchronous active-low reset
//  gpio_in   in   32        bus: w_clk=gpio_in[gpio_w_clk_bit], addr=[gpio_addr_start:gpio_addr_end]
//  gpio_out  out  32        [7:0] byte, [8] avail, [9] byte_sel (0=hi,1=lo), [10] underflow,
//                           [15:11] 0, [31:16] words_read
//  data_in   in   num_bits  AXIS tdata, zero-extended to 16 bits on capture
//  valid     in   1         AXIS tvalid
//  rdy       out  1         AXIS tready
// BEHAVIOUR
//  Reset (async, rst=0): state=EMPTY, armed=1, shadow=0, byte_sel=0, underflow=0,
//   words_read=0; gpio_out=0, rdy=0. Reset mid-word discards the held word.
//  strobe(a) = (gpio_addr==a) && w_clk && armed. A strobe disarms (armed<=0);
//   rearm (armed<=1) only on a cycle where w_clk==0. One event per w_clk pulse.
//  rdy = (state==EMPTY) registered (high the cycle after entering EMPTY; 0 out of reset,
//   1 from first clk after reset release). Capture occurs when valid&&rdy at a clk edge.
//  States:
//   EMPTY: rdy=1. valid&&rdy -> shadow<={zeros,data_in}, byte_sel<=0, state<=HI, rdy<=0.
//          strobe(rd_addr) here -> underflow<=1, no other effect.
//   HI:    gpio_out[7:0]=shadow[15:8]. strobe(rd_addr) -> byte_sel<=1, state<=LO.
//   LO:    gpio_out[7:0]=shadow[7:0]. strobe(rd_addr) -> byte_sel<=0, state<=EMPTY,
//          words_read<=words_read+1 (16-bit, wraps 0xFFFF->0x0000), rdy<=1.
//  avail = (state!=EMPTY). gpio_out is driven from registers; it reflects a state change
//   the cycle after the causing edge (read-ack to next byte visible: 1 clk).
//  Simultaneous events: strobe evaluated against pre-edge state. EMPTY + strobe + capture
//   in same cycle -> word captured AND underflow<=1. strobe(clr_addr) -> underflow<=0,
//   words_read<=0; state/shadow untouched. rd_addr==clr_addr is illegal.
//  Strobes to other addresses ignored, but still disarm until w_clk returns low.
//  Throughput: 1 word per two GPIO pulses; minimum 3 clk between capture and next rdy.
// TESTING
//  1 Reset, push data_in=0x1A5 (num_bits=9) -> rdy drops; gpio_out[10:0]=0x101 (hi 0x01,
//    avail); 1st rd strobe -> [7:0]=0xA5,[9]=1; 2nd -> avail=0, words_read=1, rdy=1.
//  2 Hold w_clk high at rd_addr for 20 clk in HI -> exactly one advance (byte_sel=1 only);
//    drop/raise w_clk -> second advance to EMPTY.
//  3 rd strobe while EMPTY, valid=0 -> underflow=1, words_read unchanged; clr_addr strobe
//    -> underflow=0, words_read=0.
//  4 Preload words_read=0xFFFF via 65535 full reads (or force) -> next word read wraps to 0.
//  5 Assert rst low in LO state with valid=1 -> gpio_out=0, rdy=0 immediately; after
//    release, next word captured fresh, starts at hi byte.
//  6 EMPTY, valid=1 and rd strobe on same edge -> word captured, underflow=1, byte_sel=0.

Source files
------------

// File: rtl/gpio_axis_reader.sv
// GPIO-to-AXIS read bridge: captures one AXI-stream word into a 16-bit shadow register
// and hands it to software a byte at a time (high byte first) on GPIO read strobes.
module gpio_axis_reader #(
  parameter int unsigned num_bits        = 9,
  parameter int unsigned rd_addr         = 2,
  parameter int unsigned clr_addr        = 3,
  parameter int unsigned gpio_w_clk_bit  = 31,
  parameter int unsigned gpio_addr_start = 30,
  parameter int unsigned gpio_addr_end   = 28
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         gpio_in,
  output logic [31:0]         gpio_out,
  input  logic [num_bits-1:0] data_in,
  input  logic                valid,
  output logic                rdy
);

  localparam int unsigned AddrW = gpio_addr_start - gpio_addr_end + 1;

  typedef enum logic [1:0] {StEmpty, StHi, StLo} state_e;

  state_e      state;
  logic        armed;
  logic [15:0] shadow;
  logic        byte_sel;
  logic        underflow;
  logic [15:0] words_read;

  logic             w_clk;
  logic [AddrW-1:0] gpio_addr;
  logic             strobe_rd;
  logic             strobe_clr;
  logic             capture;
  logic [7:0]       out_byte;
  logic             unused_gpio;

  assign w_clk       = gpio_in[gpio_w_clk_bit];
  assign gpio_addr   = gpio_in[gpio_addr_start:gpio_addr_end];
  assign unused_gpio = ^gpio_in;

  always_comb begin
    strobe_rd  = armed && w_clk && (gpio_addr == AddrW'(rd_addr));
    strobe_clr = armed && w_clk && (gpio_addr == AddrW'(clr_addr));
    // rdy is only ever high in EMPTY; the state term just keeps the capture self-evident.
    capture    = valid && rdy && (state == StEmpty);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= StEmpty;
      armed      <= 1'b1;
      shadow     <= 16'h0000;
      byte_sel   <= 1'b0;
      underflow  <= 1'b0;
      words_read <= 16'h0000;
      rdy        <= 1'b0;
    end else begin
      // One event per w_clk pulse: any address disarms, only w_clk low rearms.
      if (w_clk && armed) begin
        armed <= 1'b0;
      end else if (!w_clk) begin
        armed <= 1'b1;
      end

      if (strobe_clr) begin
        underflow  <= 1'b0;
        words_read <= 16'h0000;
      end

      case (state)
        StEmpty: begin
          if (strobe_rd) begin
            underflow <= 1'b1;
          end
          if (capture) begin
            shadow   <= 16'(data_in);
            byte_sel <= 1'b0;
            state    <= StHi;
            rdy      <= 1'b0;
          end else begin
            rdy <= 1'b1;
          end
        end
        StHi: begin
          if (strobe_rd) begin
            byte_sel <= 1'b1;
            state    <= StLo;
          end
        end
        StLo: begin
          if (strobe_rd) begin
            byte_sel   <= 1'b0;
            state      <= StEmpty;
            words_read <= words_read + 16'd1;
            rdy        <= 1'b1;
          end
        end
        default: begin
          state <= StEmpty;
          rdy   <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    unique case (state)
      StHi:    out_byte = shadow[15:8];
      StLo:    out_byte = shadow[7:0];
      default: out_byte = 8'h00;
    endcase
    gpio_out = {words_read, 5'b00000, underflow, byte_sel, (state != StEmpty), out_byte};
  end

endmodule

// File: tb/tb_gpio_axis_reader.sv
// Scoreboard bench for gpio_axis_reader: stimulus queues expected gpio_out/rdy snapshots,
// a negedge monitor pops and compares them.
module tb_gpio_axis_reader;

  localparam logic [31:0] MaskAll   = 32'hFFFF_FFFF;
  localparam logic [31:0] MaskEmpty = 32'hFFFF_FF00;
  localparam logic [2:0]  RdAddr    = 3'd2;
  localparam logic [2:0]  ClrAddr   = 3'd3;
  localparam logic [2:0]  OtherAddr = 3'd5;

  logic        clk;
  logic        rst;
  logic [31:0] gpio_in;
  logic [31:0] gpio_out;
  logic [8:0]  data_in;
  logic        valid;
  logic        rdy;

  typedef struct {
    string       name;
    logic [31:0] g;
    logic [31:0] m;
    logic        r;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  gpio_axis_reader #(
    .num_bits        (9),
    .rd_addr         (2),
    .clr_addr        (3),
    .gpio_w_clk_bit  (31),
    .gpio_addr_start (30),
    .gpio_addr_end   (28)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .gpio_in  (gpio_in),
    .gpio_out (gpio_out),
    .data_in  (data_in),
    .valid    (valid),
    .rdy      (rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare every pending expectation against the outputs away from the edge.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (((gpio_out & e.m) !== (e.g & e.m)) || (rdy !== e.r)) begin
        failures++;
        $display("FAIL %s: gpio_out=%08h rdy=%b, required gpio_out=%08h (mask %08h) rdy=%b",
                 e.name, gpio_out, rdy, e.g, e.m, e.r);
      end
    end
  end

  task automatic expect_out(input string name, input logic [31:0] g, input logic [31:0] m,
                            input logic r);
    exp_t e;
    e.name = name;
    e.g    = g;
    e.m    = m;
    e.r    = r;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic w_high(input logic [2:0] a);
    gpio_in = {1'b1, a, 28'h0};
    tick();
  endtask

  task automatic w_low();
    gpio_in[31] = 1'b0;
    tick();
  endtask

  task automatic push_word(input logic [8:0] d);
    data_in = d;
    valid   = 1'b1;
    tick();
    valid   = 1'b0;
  endtask

  initial begin
    rst     = 1'b0;
    gpio_in = 32'h0;
    data_in = 9'h0;
    valid   = 1'b0;
    #1;
    expect_out("reset_state", 32'h0000_0000, MaskAll, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    expect_out("rdy_after_release", 32'h0000_0000, MaskAll, 1'b1);

    // 1: basic word, hi then lo byte
    push_word(9'h1A5);
    expect_out("t1_hi_byte", 32'h0000_0101, MaskAll, 1'b0);
    w_high(RdAddr);
    expect_out("t1_lo_byte", 32'h0000_03A5, MaskAll, 1'b0);
    w_low();
    w_high(RdAddr);
    expect_out("t1_done", 32'h0001_0000, MaskEmpty, 1'b1);
    w_low();

    // 2: w_clk held high advances only once
    push_word(9'h0C3);
    expect_out("t2_hi_byte", 32'h0001_0100, MaskAll, 1'b0);
    gpio_in = {1'b1, RdAddr, 28'h0};
    repeat (20) tick();
    expect_out("t2_held_one_advance", 32'h0001_03C3, MaskAll, 1'b0);
    w_low();
    w_high(RdAddr);
    expect_out("t2_second_advance", 32'h0002_0000, MaskEmpty, 1'b1);
    w_low();

    // 3: underflow then clear
    w_high(RdAddr);
    expect_out("t3_underflow", 32'h0002_0400, MaskEmpty, 1'b1);
    w_low();
    w_high(ClrAddr);
    expect_out("t3_clear", 32'h0000_0000, MaskEmpty, 1'b1);
    w_low();

    // 4: words_read wraps 0xFFFF -> 0
    force dut.words_read = 16'hFFFF;
    tick();
    release dut.words_read;
    expect_out("t4_preload", 32'hFFFF_0000, MaskEmpty, 1'b1);
    push_word(9'h155);
    expect_out("t4_hi_byte", 32'hFFFF_0101, MaskAll, 1'b0);
    w_high(RdAddr);
    expect_out("t4_lo_byte", 32'hFFFF_0355, MaskAll, 1'b0);
    w_low();
    w_high(RdAddr);
    expect_out("t4_wrap", 32'h0000_0000, MaskEmpty, 1'b1);
    w_low();

    // 5: async reset in LO with valid high
    push_word(9'h0AB);
    expect_out("t5_hi_byte", 32'h0000_0100, MaskAll, 1'b0);
    w_high(RdAddr);
    expect_out("t5_lo_byte", 32'h0000_03AB, MaskAll, 1'b0);
    w_low();
    data_in = 9'h1FF;
    valid   = 1'b1;
    #1;
    rst = 1'b0;
    #1;
    expect_out("t5_async_reset", 32'h0000_0000, MaskAll, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    expect_out("t5_rdy_back", 32'h0000_0000, MaskAll, 1'b1);
    tick();
    valid = 1'b0;
    expect_out("t5_fresh_hi", 32'h0000_0101, MaskAll, 1'b0);
    w_high(RdAddr);
    expect_out("t5_fresh_lo", 32'h0000_03FF, MaskAll, 1'b0);
    w_low();
    w_high(RdAddr);
    expect_out("t5_done", 32'h0001_0000, MaskEmpty, 1'b1);
    w_low();

    // 6: capture and underflow strobe on the same edge
    data_in = 9'h123;
    valid   = 1'b1;
    w_high(RdAddr);
    valid   = 1'b0;
    expect_out("t6_capture_and_underflow", 32'h0001_0501, MaskAll, 1'b0);
    w_low();

    // Other-address strobe disarms until w_clk drops
    w_high(OtherAddr);
    expect_out("other_addr_ignored", 32'h0001_0501, MaskAll, 1'b0);
    gpio_in = {1'b1, RdAddr, 28'h0};
    tick();
    expect_out("still_disarmed", 32'h0001_0501, MaskAll, 1'b0);
    w_low();
    w_high(RdAddr);
    expect_out("rearmed_advance", 32'h0001_0723, MaskAll, 1'b0);
    w_low();

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: pending=%0d, required 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
